sbox_layer_iter: RTL and testbench

Iterative, parametrised S-box substitution engine for the lightweight cipher datapath. It generalises the fixed 16-bit combinational byte-slice substitution to a configurable state width, slice parallelism and round count. It processes the state over multiple cycles behind valid/ready handshakes and supports an optional inverse mode. It sits between the key-mix stage and the permutation layer of the round pipeline.

---
 rtl/sbox_layer_pkg.sv | 27 ++
 rtl/sbox_layer_iter_if.sv | 23 ++
 rtl/sbox_layer_iter_sbox8_lane.sv | 10 +
 rtl/sbox_layer_iter.sv | 121 ++++++++++++
 tb/tb_sbox_layer_iter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sbox_layer_pkg.sv
// Shared S-box tables, substitution helpers and FSM state encoding for sbox_layer_iter.
package sbox_layer_pkg;

   // Nibble i of each constant is the table entry for index i.
   localparam logic [63:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

   typedef enum logic [1:0] {
      SB_IDLE = 2'd0,
      SB_BUSY = 2'd1,
      SB_DONE = 2'd2
   } sbox_layer_state_e;

   function automatic logic [3:0] sbox4(logic [3:0] x);
      return SBOX_FWD[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] sbox4_inv(logic [3:0] x);
      return SBOX_INV[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [7:0] sbox8(logic [7:0] b, logic inv);
      return inv ? {sbox4_inv(b[7:4]), sbox4_inv(b[3:0])}
                 : {sbox4(b[7:4]), sbox4(b[3:0])};
   endfunction

endpackage

// File: rtl/sbox_layer_iter_if.sv
// Input/output handshake bundle for sbox_layer_iter; master is the upstream/downstream side.
interface sbox_layer_iter_if #(
   parameter int STATE_W = 64
);
   logic               in_valid_i;
   logic               in_ready_o;
   logic [STATE_W-1:0] in_state_i;
   logic               inv_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [STATE_W-1:0] out_state_o;
   logic               busy_o;

   modport master (
      output in_valid_i, in_state_i, inv_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_state_o, busy_o
   );

   modport slave (
      input  in_valid_i, in_state_i, inv_i, out_ready_i,
      output in_ready_o, out_valid_o, out_state_o, busy_o
   );
endinterface

// File: rtl/sbox_layer_iter_sbox8_lane.sv
// One combinational 8-bit substitution slice (two independent 4-bit S-boxes).
module sbox8_lane
   import sbox_layer_pkg::*;
(
   input  logic [7:0] din,
   input  logic       inv,
   output logic [7:0] dout
);
   assign dout = sbox8(din, inv);
endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative S-box layer: LANES byte slices per cycle, ROUNDS full passes per transaction.
// Optional inverse mode is compiled in with SBOX_LAYER_INV_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new state; capture on in_valid_i
// BUSY  | substitute one LANES-wide window per cycle, LSB window first
// DONE  | hold result on out_state_o until out_ready_i
module sbox_layer_iter
   import sbox_layer_pkg::*;
#(
   parameter int STATE_W = 64,
   parameter int LANES   = 1,
   parameter int ROUNDS  = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   sbox_layer_iter_if.slave bus
);
   localparam int NSLICE  = STATE_W / 8;
   localparam int NSTEP   = NSLICE / LANES;
   localparam int LW      = LANES * 8;
   localparam int STEP_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int ROUND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   localparam logic [1:0] ST_IDLE = 2'(SB_IDLE);
   localparam logic [1:0] ST_BUSY = 2'(SB_BUSY);
   localparam logic [1:0] ST_DONE = 2'(SB_DONE);

   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NSTEP - 1);
   localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);

   if ((STATE_W % 8) != 0 || STATE_W < 16 || LANES < 1 ||
       (NSLICE % LANES) != 0 || ROUNDS < 1) begin : g_bad_cfg
      $error("sbox_layer_iter: illegal STATE_W/LANES/ROUNDS combination");
   end

   logic [1:0]         state_q;
   logic [STATE_W-1:0] data_q;
   logic [STATE_W-1:0] data_d;
   logic [STEP_W-1:0]  step_q;
   logic [ROUND_W-1:0] round_q;
   logic               inv_q;
   logic [31:0]        off;
   logic [LW-1:0]      win;
   logic [LW-1:0]      win_sub;

   // Window selection by shifting keeps the datapath index-width agnostic.
   assign off = 32'(step_q) * 32'(LW);
   assign win = LW'(data_q >> off);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sbox8_lane u_lane (
         .din  (win[l*8 +: 8]),
         .inv  (inv_q),
         .dout (win_sub[l*8 +: 8])
      );
   end

   always_comb begin
      data_d = (data_q & ~(STATE_W'({LW{1'b1}}) << off)) | (STATE_W'(win_sub) << off);
   end

`ifdef SBOX_LAYER_INV_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inv_q <= 1'b0;
      end else if (state_q == ST_IDLE && bus.in_valid_i) begin
         inv_q <= bus.inv_i;
      end
   end
`else
   assign inv_q = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         step_q  <= '0;
         round_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid_i) begin
                  data_q  <= bus.in_state_i;
                  step_q  <= '0;
                  round_q <= '0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               data_q <= data_d;
               if (step_q == STEP_LAST) begin
                  step_q <= '0;
                  if (round_q == ROUND_LAST) begin
                     round_q <= '0;
                     state_q <= ST_DONE;
                  end else begin
                     round_q <= round_q + 1'b1;
                  end
               end else begin
                  step_q <= step_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready_o  = (state_q == ST_IDLE);
   assign bus.busy_o      = (state_q == ST_BUSY);
   assign bus.out_valid_o = (state_q == ST_DONE);
   assign bus.out_state_o = data_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Bench for sbox_layer_iter: three configurations driven through a shared task set.
module tb_sbox_layer_iter;
   import sbox_layer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-configuration drive/observe arrays: 0 = 16/1/1, 1 = 64/2/2, 2 = 32/4/3
   logic        vld  [3];
   logic        inv  [3];
   logic        ordy [3];
   logic [63:0] din  [3];
   logic        rdy  [3];
   logic        ovld [3];
   logic        bsy  [3];
   logic [63:0] dout [3];

   int cfg_w [3] = '{16, 64, 32};
   int cfg_r [3] = '{1, 2, 3};
   int cfg_n [3] = '{2, 4, 1};

   int fwd_t [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
   int inv_t [16] = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};

   sbox_layer_iter_if #(.STATE_W(16)) bus_a ();
   sbox_layer_iter_if #(.STATE_W(64)) bus_b ();
   sbox_layer_iter_if #(.STATE_W(32)) bus_c ();

   assign bus_a.in_valid_i  = vld[0];
   assign bus_a.inv_i       = inv[0];
   assign bus_a.out_ready_i = ordy[0];
   assign bus_a.in_state_i  = din[0][15:0];
   assign rdy[0]  = bus_a.in_ready_o;
   assign ovld[0] = bus_a.out_valid_o;
   assign bsy[0]  = bus_a.busy_o;
   assign dout[0] = 64'(bus_a.out_state_o);

   assign bus_b.in_valid_i  = vld[1];
   assign bus_b.inv_i       = inv[1];
   assign bus_b.out_ready_i = ordy[1];
   assign bus_b.in_state_i  = din[1];
   assign rdy[1]  = bus_b.in_ready_o;
   assign ovld[1] = bus_b.out_valid_o;
   assign bsy[1]  = bus_b.busy_o;
   assign dout[1] = bus_b.out_state_o;

   assign bus_c.in_valid_i  = vld[2];
   assign bus_c.inv_i       = inv[2];
   assign bus_c.out_ready_i = ordy[2];
   assign bus_c.in_state_i  = din[2][31:0];
   assign rdy[2]  = bus_c.in_ready_o;
   assign ovld[2] = bus_c.out_valid_o;
   assign bsy[2]  = bus_c.busy_o;
   assign dout[2] = 64'(bus_c.out_state_o);

   sbox_layer_iter #(.STATE_W(16), .LANES(1), .ROUNDS(1)) u_dut_a (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_a.slave));
   sbox_layer_iter #(.STATE_W(64), .LANES(2), .ROUNDS(2)) u_dut_b (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_b.slave));
   sbox_layer_iter #(.STATE_W(32), .LANES(4), .ROUNDS(3)) u_dut_c (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_c.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wmask(int w);
      return (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
   endfunction

   // Every nibble of the state goes through the table once per round.
   function automatic logic [63:0] ref_sub(logic [63:0] x, int w, int rounds, logic sel_inv);
      logic [63:0] y;
      logic        use_inv;
      y = x & wmask(w);
`ifdef SBOX_LAYER_INV_EN
      use_inv = sel_inv;
`else
      use_inv = 1'b0;
`endif
      for (int r = 0; r < rounds; r++)
         for (int i = 0; i < w / 4; i++)
            y[i*4 +: 4] = use_inv ? 4'(inv_t[y[i*4 +: 4]]) : 4'(fwd_t[y[i*4 +: 4]]);
      return y;
   endfunction

   // One transaction with latency check and optional backpressure hold with a junk input.
   task automatic xact(input int d, input logic [63:0] x, input logic mode, input int hold,
                       output logic [63:0] res);
      int          lat;
      int          wt;
      logic [63:0] held;
      string       tg;
      tg = $sformatf("cfg%0d", d);
      @(negedge clk);
      vld[d] = 1'b1; din[d] = x & wmask(cfg_w[d]); inv[d] = mode; ordy[d] = 1'b0;
      wt = 0;
      while (!rdy[d] && wt < 100) begin @(negedge clk); wt++; end
      chk({tg, "_accept_timeout"}, 64'(wt < 100), 64'd1);
      @(posedge clk);
      @(negedge clk);
      vld[d] = 1'b0;
      lat = 0;
      while (!ovld[d] && lat < 200) begin @(negedge clk); lat++; end
      chk({tg, "_latency"}, 64'(lat), 64'(cfg_n[d] * cfg_r[d]));
      chk({tg, "_data"}, dout[d], ref_sub(x, cfg_w[d], cfg_r[d], mode));
      res  = dout[d];
      held = dout[d];
      for (int i = 0; i < hold; i++) begin
         vld[d] = 1'b1; din[d] = ~x & wmask(cfg_w[d]);
         @(negedge clk);
         chk({tg, "_bp_valid"}, 64'(ovld[d]), 64'd1);
         chk({tg, "_bp_data"}, dout[d], held);
         chk({tg, "_bp_ready"}, 64'(rdy[d]), 64'd0);
      end
      vld[d] = 1'b0; ordy[d] = 1'b1;
      @(negedge clk);
      ordy[d] = 1'b0;
      chk({tg, "_post_ready"}, 64'(rdy[d]), 64'd1);
      chk({tg, "_post_valid"}, 64'(ovld[d]), 64'd0);
      @(negedge clk);
      chk({tg, "_post_busy"}, 64'(bsy[d]), 64'd0);
   endtask

   task automatic run_random(input int d, input int n);
      logic [63:0] exp_q [$];
      int          sent = 0;
      int          got  = 0;
      int          cyc  = 0;
      while (got < n && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (sent < n) begin
            vld[d] = 1'($urandom_range(0, 1));
            din[d] = {$urandom, $urandom} & wmask(cfg_w[d]);
            inv[d] = 1'($urandom_range(0, 1));
         end else begin
            vld[d] = 1'b0;
         end
         ordy[d] = 1'($urandom_range(0, 1));
         if (vld[d] && rdy[d]) begin
            exp_q.push_back(ref_sub(din[d], cfg_w[d], cfg_r[d], inv[d]));
            sent++;
         end
         if (ovld[d] && ordy[d]) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("cfg%0d_rand_extra", d), 64'd1, 64'd0);
            end else begin
               chk($sformatf("cfg%0d_rand_%0d", d, got), dout[d], exp_q.pop_front());
            end
            got++;
         end
      end
      chk($sformatf("cfg%0d_rand_count", d), 64'(got), 64'(n));
      chk($sformatf("cfg%0d_rand_left", d), 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      vld[d] = 1'b0; ordy[d] = 1'b0;
   endtask

   initial begin
      logic [63:0] r;
      logic        seen;
      for (int d = 0; d < 3; d++) begin
         vld[d] = 1'b0; inv[d] = 1'b0; ordy[d] = 1'b0; din[d] = '0;
      end
      #23;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("cfg%0d_rst_ready", d), 64'(rdy[d]), 64'd1);
         chk($sformatf("cfg%0d_rst_valid", d), 64'(ovld[d]), 64'd0);
         chk($sformatf("cfg%0d_rst_busy", d), 64'(bsy[d]), 64'd0);
         chk($sformatf("cfg%0d_rst_state", d), dout[d], 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      xact(0, 64'hABCD, 1'b0, 0, r);
      chk("a_fwd_abcd", r, 64'hF847);
      xact(0, 64'hF847, 1'b1, 0, r);
`ifdef SBOX_LAYER_INV_EN
      chk("a_inv_f847", r, 64'hABCD);
`else
      chk("a_inv_ignored", r, 64'h239D);
`endif
      xact(1, 64'h0, 1'b0, 0, r);
      chk("b_zero", r, 64'h4444_4444_4444_4444);
      xact(2, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, r);
      xact(1, {$urandom, $urandom}, 1'b0, 10, r);

      // Reset in the middle of a BUSY phase discards the transaction.
      @(negedge clk);
      vld[1] = 1'b1; din[1] = 64'h0123_4567_89AB_CDEF; inv[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vld[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("b_midrst_busy_before", 64'(bsy[1]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("b_midrst_ready", 64'(rdy[1]), 64'd1);
      chk("b_midrst_busy", 64'(bsy[1]), 64'd0);
      chk("b_midrst_state", dout[1], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ordy[1] = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ovld[1]) seen = 1'b1;
      end
      ordy[1] = 1'b0;
      chk("b_midrst_no_out", 64'(seen), 64'd0);
      xact(1, {$urandom, $urandom}, 1'b1, 0, r);

      run_random(1, 20);
      run_random(2, 20);
      run_random(0, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
